// File: rtl/bpm_beat_scheduler.sv
// Tempo-to-period converter (restoring divider) and beat/accent scheduler.
// A new tempo never interrupts the running beat; the old period holds until the new one is ready.
`timescale 1ns/1ps
module bpm_beat_scheduler #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int BPM_MIN = 20,
    parameter int BPM_MAX = 300
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [33:0] i_bpm,
    input  logic        i_bpm_changed,
    input  logic        i_enable,
    input  logic [3:0]  i_beats_per_bar,
    output logic        o_beat,
    output logic        o_accent,
    output logic [3:0]  o_beat_index,
    output logic [31:0] o_period,
    output logic        o_period_valid,
    output logic        o_busy,
    output logic        o_clamped
);

    localparam logic [63:0] DVD64 = 64'(CLK_HZ) * 64'd60;
    localparam logic [31:0] DVD   = 32'(DVD64);
    localparam logic [33:0] BMIN  = 34'(BPM_MIN);
    localparam logic [33:0] BMAX  = 34'(BPM_MAX);

    if (DVD64 >= 64'h1_0000_0000) begin : g_bad_dividend
        $error("CLK_HZ*60 does not fit in 32 bits");
    end
    if (BPM_MIN < 1 || BPM_MAX < BPM_MIN) begin : g_bad_range
        $error("BPM_MIN/BPM_MAX range is invalid");
    end

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DIV, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [33:0] shadow_q;
    logic        pend_q;
    logic [33:0] div_q;
    logic [31:0] dvd_q;
    logic [31:0] rem_q;
    logic [31:0] quot_q;
    logic [4:0]  cnt_q;
    logic [31:0] period_q;
    logic        valid_q;
    logic        clamped_q;
    logic [31:0] tick_q;
    logic [3:0]  idx_q;
    logic        run_q;
    logic        beat_q;
    logic        accent_q;

    logic [33:0] bpm_c;
    logic [32:0] trial;
    logic        ge;
    logic [31:0] rem_d;
    logic [31:0] quot_d;
    logic        active;
    logic [3:0]  idx_nx;

    // Clamp of the tempo that the next LOAD will use
    always_comb begin
        bpm_c = shadow_q;
        if (shadow_q < BMIN) begin
            bpm_c = BMIN;
        end else if (shadow_q > BMAX) begin
            bpm_c = BMAX;
        end
    end

    // One restoring-division step: shift in next dividend bit, subtract if it fits
    always_comb begin
        trial  = {rem_q, dvd_q[31]};
        ge     = ({1'b0, trial} >= div_q);
        rem_d  = ge ? 32'({1'b0, trial} - div_q) : trial[31:0];
        quot_d = {quot_q[30:0], ge};
    end

    // Divider control next-state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (i_bpm_changed || pend_q) state_d = S_LOAD;
            S_LOAD: state_d = S_DIV;
            S_DIV:  if (cnt_q == 5'd31) state_d = S_DONE;
            S_DONE: state_d = (pend_q || i_bpm_changed) ? S_LOAD : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Divider datapath, shadow tempo, pending flag and published period
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q   <= S_IDLE;
            shadow_q  <= '0;
            pend_q    <= 1'b0;
            div_q     <= '0;
            dvd_q     <= '0;
            rem_q     <= '0;
            quot_q    <= '0;
            cnt_q     <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            clamped_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (i_bpm_changed) shadow_q <= i_bpm;
            if (i_bpm_changed && state_q != S_IDLE) begin
                pend_q <= 1'b1;
            end else if (state_q == S_LOAD) begin
                pend_q <= 1'b0;
            end
            if (state_q == S_LOAD) begin
                div_q     <= bpm_c;
                clamped_q <= (shadow_q != bpm_c);
                dvd_q     <= DVD;
                rem_q     <= '0;
                quot_q    <= '0;
                cnt_q     <= '0;
            end else if (state_q == S_DIV) begin
                dvd_q  <= {dvd_q[30:0], 1'b0};
                rem_q  <= rem_d;
                quot_q <= quot_d;
                cnt_q  <= cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    period_q <= quot_d;
                    valid_q  <= 1'b1;
                end
            end
        end
    end

    assign active = i_enable && valid_q;
    assign idx_nx = (i_beats_per_bar <= 4'd1 || idx_q >= i_beats_per_bar - 4'd1)
                  ? 4'd0 : idx_q + 4'd1;

    // Beat generator: immediate downbeat on activation, then one beat per period
    always_ff @(posedge i_clk) begin
        if (!i_reset_n || !active) begin
            tick_q   <= '0;
            idx_q    <= '0;
            run_q    <= 1'b0;
            beat_q   <= 1'b0;
            accent_q <= 1'b0;
        end else if (!run_q) begin
            run_q    <= 1'b1;
            tick_q   <= '0;
            idx_q    <= '0;
            beat_q   <= 1'b1;
            accent_q <= 1'b1;
        end else if (tick_q >= period_q - 32'd1) begin
            tick_q   <= '0;
            idx_q    <= idx_nx;
            beat_q   <= 1'b1;
            accent_q <= (idx_nx == 4'd0);
        end else begin
            tick_q   <= tick_q + 32'd1;
            beat_q   <= 1'b0;
            accent_q <= 1'b0;
        end
    end

    assign o_beat         = beat_q;
    assign o_accent       = accent_q;
    assign o_beat_index   = idx_q;
    assign o_period       = period_q;
    assign o_period_valid = valid_q;
    assign o_busy         = (state_q != S_IDLE);
    assign o_clamped      = clamped_q;

endmodule

// File: tb/tb_bpm_beat_scheduler.sv
// Directed bench for bpm_beat_scheduler at CLK_HZ=1000 (dividend 60000).
// Inputs change and outputs are sampled on the falling clock edge.
`timescale 1ns/1ps
module tb_bpm_beat_scheduler;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [33:0] bpm;
    logic        chg;
    logic        en;
    logic [3:0]  bpb;
    logic        beat;
    logic        accent;
    logic [3:0]  idx;
    logic [31:0] period;
    logic        valid;
    logic        busy;
    logic        clamped;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bpm_beat_scheduler #(
        .CLK_HZ (1000),
        .BPM_MIN(20),
        .BPM_MAX(300)
    ) dut (
        .i_clk          (clk),
        .i_reset_n      (rst_n),
        .i_bpm          (bpm),
        .i_bpm_changed  (chg),
        .i_enable       (en),
        .i_beats_per_bar(bpb),
        .o_beat         (beat),
        .o_accent       (accent),
        .o_beat_index   (idx),
        .o_period       (period),
        .o_period_valid (valid),
        .o_busy         (busy),
        .o_clamped      (clamped)
    );

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // One-cycle strobe; returns in the cycle after the strobe (LOAD)
    task automatic strobe(input logic [33:0] v);
        @(negedge clk);
        bpm = v;
        chg = 1'b1;
        @(negedge clk);
        chg = 1'b0;
    endtask

    // Returns in the cycle o_period is published (strobe + 34)
    task automatic strobe_wait(input logic [33:0] v);
        strobe(v);
        cycles(33);
    endtask

    task automatic wait_beat(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!beat && n < 5000);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cycles(3);
        total++;
        if ({beat, accent, idx, period, valid, busy, clamped} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got b=%0b a=%0b i=%0d p=%0d v=%0b busy=%0b c=%0b want all 0",
                     beat, accent, idx, period, valid, busy, clamped);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic_120();
        int n;
        strobe(34'd120);
        total++;
        if (busy !== 1'b1 || valid !== 1'b0) begin
            bad++;
            $display("FAIL load_busy got busy=%0b valid=%0b want 1/0", busy, valid);
        end
        cycles(32);
        total++;
        if (valid !== 1'b0) begin
            bad++;
            $display("FAIL early_valid at T+33 got %0b want 0", valid);
        end
        cycles(1);
        total++;
        if (valid !== 1'b1 || period !== 32'd500 || busy !== 1'b1) begin
            bad++;
            $display("FAIL period_120 got v=%0b p=%0d busy=%0b want 1/500/1", valid, period, busy);
        end
        cycles(1);
        total++;
        if (beat !== 1'b1 || accent !== 1'b1 || idx !== 4'd0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL downbeat got b=%0b a=%0b i=%0d busy=%0b want 1/1/0/0", beat, accent, idx, busy);
        end
        for (int k = 1; k <= 8; k++) begin
            wait_beat(n);
            total++;
            if (n !== 500 || idx !== 4'(k % 4) || accent !== (k % 4 == 0)) begin
                bad++;
                $display("FAIL beat_%0d got gap=%0d i=%0d a=%0b want 500/%0d/%0b",
                         k, n, idx, accent, k % 4, (k % 4 == 0));
            end
        end
    endtask

    task automatic test_clamp();
        strobe_wait(34'd0);
        total++;
        if (period !== 32'd3000 || clamped !== 1'b1) begin
            bad++;
            $display("FAIL clamp_low got p=%0d c=%0b want 3000/1", period, clamped);
        end
        strobe_wait(34'd1000);
        total++;
        if (period !== 32'd200 || clamped !== 1'b1) begin
            bad++;
            $display("FAIL clamp_high got p=%0d c=%0b want 200/1", period, clamped);
        end
        strobe_wait(34'd60);
        total++;
        if (period !== 32'd1000 || clamped !== 1'b0) begin
            bad++;
            $display("FAIL no_clamp got p=%0d c=%0b want 1000/0", period, clamped);
        end
    endtask

    task automatic test_back_to_back();
        int p500 = -1;
        int p400 = -1;
        int saw600 = 0;
        strobe(34'd120);
        for (int c = 2; c <= 75; c++) begin
            @(negedge clk);
            if (period == 32'd600) saw600++;
            if (period == 32'd500 && p500 < 0) p500 = c;
            if (period == 32'd400 && p400 < 0) p400 = c;
            chg = 1'b0;
            if (c == 5) begin
                bpm = 34'd100;
                chg = 1'b1;
            end
            if (c == 10) begin
                bpm = 34'd150;
                chg = 1'b1;
            end
        end
        chg = 1'b0;
        total++;
        if (p500 !== 34 || p400 !== 68) begin
            bad++;
            $display("FAIL pending_timing got 500@%0d 400@%0d want 34/68", p500, p400);
        end
        total++;
        if (saw600 !== 0) begin
            bad++;
            $display("FAIL intermediate got %0d cycles of 600 want 0", saw600);
        end
    endtask

    task automatic test_period_update();
        int n;
        strobe_wait(34'd120);
        wait_beat(n);
        cycles(365);
        strobe(34'd200);
        wait_beat(n);
        total++;
        if (n !== 34 || period !== 32'd300) begin
            bad++;
            $display("FAIL shrink_beat got gap=%0d p=%0d want 34/300", n, period);
        end
        wait_beat(n);
        total++;
        if (n !== 300) begin
            bad++;
            $display("FAIL new_period_gap got %0d want 300", n);
        end
    endtask

    task automatic test_enable();
        int n;
        int beats = 0;
        int k = 0;
        do begin
            wait_beat(n);
            k++;
        end while (idx !== 4'd2 && k < 8);
        en = 1'b0;
        cycles(1);
        total++;
        if (beat !== 1'b0 || idx !== 4'd0) begin
            bad++;
            $display("FAIL disable got b=%0b i=%0d want 0/0 (reached idx2 after %0d)", beat, idx, k);
        end
        for (int c = 0; c < 700; c++) begin
            @(negedge clk);
            if (beat || accent || idx != 4'd0) beats++;
        end
        total++;
        if (beats !== 0) begin
            bad++;
            $display("FAIL silent got %0d active cycles want 0", beats);
        end
        en = 1'b1;
        cycles(1);
        total++;
        if (beat !== 1'b1 || accent !== 1'b1 || idx !== 4'd0) begin
            bad++;
            $display("FAIL reenable got b=%0b a=%0b i=%0d want 1/1/0", beat, accent, idx);
        end
    endtask

    task automatic test_reset_mid_div();
        strobe(34'd60);
        cycles(10);
        rst_n = 1'b0;
        cycles(1);
        total++;
        if ({beat, accent, idx, period, valid, busy, clamped} !== '0) begin
            bad++;
            $display("FAIL reset_mid_div got b=%0b a=%0b i=%0d p=%0d v=%0b busy=%0b c=%0b want all 0",
                     beat, accent, idx, period, valid, busy, clamped);
        end
        rst_n = 1'b1;
        cycles(40);
        total++;
        if (valid !== 1'b0 || busy !== 1'b0 || beat !== 1'b0) begin
            bad++;
            $display("FAIL aborted_div got v=%0b busy=%0b b=%0b want 0/0/0", valid, busy, beat);
        end
        strobe_wait(34'd240);
        total++;
        if (period !== 32'd250 || valid !== 1'b1 || clamped !== 1'b0) begin
            bad++;
            $display("FAIL period_240 got p=%0d v=%0b c=%0b want 250/1/0", period, valid, clamped);
        end
        cycles(1);
        total++;
        if (beat !== 1'b1 || accent !== 1'b1) begin
            bad++;
            $display("FAIL downbeat_after_reset got b=%0b a=%0b want 1/1", beat, accent);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bpm   = '0;
        chg   = 1'b0;
        en    = 1'b1;
        bpb   = 4'd4;
        test_reset();
        test_basic_120();
        test_clamp();
        test_back_to_back();
        test_period_update();
        test_enable();
        test_reset_mid_div();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
